// File: rtl/ex_stage_ctrl.sv
// Execute-stage control: ID/EX and EX/MEM pipeline registers, operand forwarding,
// load-use stall detection and taken-branch redirect/flush.
module ex_stage_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [2:0]      id_funct3,
  input  logic [6:0]      id_funct7,
  input  logic [1:0]      id_aluop,
  input  logic            id_alusrc,
  input  logic            id_branch,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic            id_regwrite,
  output logic [XLEN-1:0] ex_A,
  output logic [XLEN-1:0] ex_B,
  output logic [XLEN-1:0] ex_C,
  output logic [XLEN-1:0] ex_pc,
  output logic [2:0]      ex_funct3,
  output logic [6:0]      ex_funct7,
  output logic [1:0]      ex_aluop,
  output logic            ex_alusrc,
  input  logic            ex_zero,
  input  logic [XLEN-1:0] ex_result,
  input  logic [XLEN-1:0] ex_target,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            exm_valid,
  output logic [4:0]      exm_rd,
  output logic            exm_regwrite,
  output logic            exm_memread,
  output logic            exm_memwrite,
  output logic [XLEN-1:0] exm_result,
  output logic [XLEN-1:0] exm_store_data,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);

  localparam int STAGES = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [1:0]      aluop;
    logic            alusrc;
    logic            branch;
    logic            memread;
    logic            memwrite;
    logic            regwrite;
  } idex_t;

  typedef struct packed {
    logic [4:0]      rd;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
  } exmem_t;

  idex_t           ex_q, id_d;
  exmem_t          exm_q, exm_d;
  logic [STAGES:1] vld_pipe;   // [1] = ID/EX valid, [2] = EX/MEM valid
  logic            ex_v, stall, capture, exm_fwd_ok;
  logic [XLEN-1:0] fwd_a, fwd_b;

  // EX/MEM wins over WB; loads in EX/MEM have no data yet so never forward
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] latched,
    input logic            m_ok,
    input logic [4:0]      m_rd,
    input logic [XLEN-1:0] m_val,
    input logic            w_ok,
    input logic [4:0]      w_rd,
    input logic [XLEN-1:0] w_val
  );
    if (m_ok && m_rd != 5'd0 && m_rd == rs) return m_val;
    if (w_ok && w_rd != 5'd0 && w_rd == rs) return w_val;
    return latched;
  endfunction

  assign ex_v      = vld_pipe[1];
  assign exm_valid = vld_pipe[STAGES];

  assign exm_fwd_ok = exm_valid && exm_q.regwrite && !exm_q.memread;
  assign fwd_a = fwd_sel(ex_q.rs1, ex_q.rs1_data, exm_fwd_ok, exm_q.rd, exm_q.result,
                         wb_regwrite, wb_rd, wb_data);
  assign fwd_b = fwd_sel(ex_q.rs2, ex_q.rs2_data, exm_fwd_ok, exm_q.rd, exm_q.result,
                         wb_regwrite, wb_rd, wb_data);

  assign stall = ex_v && ex_q.memread && (ex_q.rd != 5'd0) &&
                 ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2)) && id_valid;

  // Redirect beats stall; the instruction in ID is wrong-path and is dropped
  assign redirect    = ex_v && ex_q.branch && ex_zero;
  assign redirect_pc = redirect ? ex_target : '0;
  assign id_ready    = redirect || !stall;
  assign capture     = id_valid && id_ready && !redirect;

  always_comb begin
    id_d          = '0;
    id_d.pc       = id_pc;
    id_d.rs1_data = id_rs1_data;
    id_d.rs2_data = id_rs2_data;
    id_d.imm      = id_imm;
    id_d.rs1      = id_rs1;
    id_d.rs2      = id_rs2;
    id_d.rd       = id_rd;
    id_d.funct3   = id_funct3;
    id_d.funct7   = id_funct7;
    id_d.aluop    = id_aluop;
    id_d.alusrc   = id_alusrc;
    id_d.branch   = id_branch;
    id_d.memread  = id_memread;
    id_d.memwrite = id_memwrite;
    id_d.regwrite = id_regwrite;
  end

  always_comb begin
    exm_d            = '0;
    exm_d.rd         = ex_q.rd;
    exm_d.regwrite   = ex_v && ex_q.regwrite && !ex_q.branch;
    exm_d.memread    = ex_v && ex_q.memread;
    exm_d.memwrite   = ex_v && ex_q.memwrite;
    exm_d.result     = ex_result;
    exm_d.store_data = fwd_b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      ex_q     <= '0;
      exm_q    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], capture};
      exm_q    <= exm_d;
      if (capture) begin
        ex_q <= id_d;
      end else begin
        // bubble: zero every control field so the datapath sees a clean no-op
        ex_q.funct3   <= '0;
        ex_q.funct7   <= '0;
        ex_q.aluop    <= '0;
        ex_q.alusrc   <= 1'b0;
        ex_q.branch   <= 1'b0;
        ex_q.memread  <= 1'b0;
        ex_q.memwrite <= 1'b0;
        ex_q.regwrite <= 1'b0;
      end
    end
  end

  assign ex_A      = fwd_a;
  assign ex_B      = fwd_b;
  assign ex_C      = ex_q.imm;
  assign ex_pc     = ex_q.pc;
  assign ex_funct3 = ex_q.funct3;
  assign ex_funct7 = ex_q.funct7;
  assign ex_aluop  = ex_q.aluop;
  assign ex_alusrc = ex_q.alusrc;

  assign exm_rd         = exm_q.rd;
  assign exm_regwrite   = exm_q.regwrite;
  assign exm_memread    = exm_q.memread;
  assign exm_memwrite   = exm_q.memwrite;
  assign exm_result     = exm_q.result;
  assign exm_store_data = exm_q.store_data;

endmodule

// File: tb/tb_ex_stage_ctrl.sv
// Table-driven bench for ex_stage_ctrl with a behavioural ALU/branch datapath model.
module tb_ex_stage_ctrl;

  logic        clk, reset;
  logic        id_valid, id_ready;
  logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic [1:0]  id_aluop;
  logic        id_alusrc, id_branch, id_memread, id_memwrite, id_regwrite;
  logic [63:0] ex_A, ex_B, ex_C, ex_pc;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic [1:0]  ex_aluop;
  logic        ex_alusrc, ex_zero;
  logic [63:0] ex_result, ex_target;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        exm_valid, exm_regwrite, exm_memread, exm_memwrite;
  logic [4:0]  exm_rd;
  logic [63:0] exm_result, exm_store_data;
  logic        redirect;
  logic [63:0] redirect_pc;

  int errors = 0;
  int checks = 0;

  ex_stage_ctrl #(.XLEN(64)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_funct3(id_funct3), .id_funct7(id_funct7), .id_aluop(id_aluop),
    .id_alusrc(id_alusrc), .id_branch(id_branch), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_regwrite(id_regwrite),
    .ex_A(ex_A), .ex_B(ex_B), .ex_C(ex_C), .ex_pc(ex_pc),
    .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc),
    .ex_zero(ex_zero), .ex_result(ex_result), .ex_target(ex_target),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .exm_valid(exm_valid), .exm_rd(exm_rd), .exm_regwrite(exm_regwrite),
    .exm_memread(exm_memread), .exm_memwrite(exm_memwrite),
    .exm_result(exm_result), .exm_store_data(exm_store_data),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Execute datapath stand-in: add/sub ALU, equality zero flag, pc + imm*2 target
  logic [63:0] opb;
  always_comb begin
    opb = ex_alusrc ? ex_C : ex_B;
    if (ex_aluop == 2'b01 || (ex_aluop == 2'b10 && ex_funct7[5])) ex_result = ex_A - opb;
    else ex_result = ex_A + opb;
    ex_zero   = (ex_A == ex_B);
    ex_target = ex_pc + (ex_C << 1);
  end

  typedef struct packed {
    logic v;
    logic [63:0] pc, r1d, r2d, imm;
    logic [4:0] rs1, rs2, rd;
    logic [6:0] f7;
    logic [1:0] aluop;
    logic alusrc, br, mr, rw;
  } inst_t;

  typedef struct {
    inst_t ins;
    logic wbw; logic [4:0] wbrd; logic [63:0] wbd;
    logic rdy, redir; logic [63:0] rpc;
    logic ca; logic [63:0] a;
    logic cb; logic [63:0] b;
    logic mv; logic [63:0] mres; logic mrw;
  } vec_t;

  function automatic inst_t alu(int rd, int rs1, int rs2, longint r1d, longint r2d, int f7);
    inst_t i = '0;
    i.v = 1'b1; i.rd = 5'(rd); i.rs1 = 5'(rs1); i.rs2 = 5'(rs2);
    i.r1d = 64'(r1d); i.r2d = 64'(r2d); i.f7 = 7'(f7);
    i.aluop = 2'b10; i.rw = 1'b1;
    return i;
  endfunction

  function automatic inst_t ld(int rd, int rs1, longint r1d);
    inst_t i = '0;
    i.v = 1'b1; i.rd = 5'(rd); i.rs1 = 5'(rs1); i.r1d = 64'(r1d);
    i.alusrc = 1'b1; i.mr = 1'b1; i.rw = 1'b1;
    return i;
  endfunction

  // Branches carry regwrite=1 on purpose: EX/MEM must force it low
  function automatic inst_t beq(longint pc, longint r1d, longint r2d, longint imm);
    inst_t i = '0;
    i.v = 1'b1; i.pc = 64'(pc); i.rs1 = 5'd7; i.rs2 = 5'd8;
    i.r1d = 64'(r1d); i.r2d = 64'(r2d); i.imm = 64'(imm);
    i.aluop = 2'b01; i.br = 1'b1; i.rw = 1'b1;
    return i;
  endfunction

  function automatic vec_t mkv(inst_t ins, int wbw, int wbrd, longint wbd,
                               int rdy, int redir, longint rpc, int ca, longint a,
                               int cb, longint b, int mv, longint mres, int mrw);
    vec_t t;
    t.ins = ins; t.wbw = (wbw != 0); t.wbrd = 5'(wbrd); t.wbd = 64'(wbd);
    t.rdy = (rdy != 0); t.redir = (redir != 0); t.rpc = 64'(rpc);
    t.ca = (ca != 0); t.a = 64'(a); t.cb = (cb != 0); t.b = 64'(b);
    t.mv = (mv != 0); t.mres = 64'(mres); t.mrw = (mrw != 0);
    return t;
  endfunction

  task automatic drive(inst_t i, logic wbw, logic [4:0] wbrd, logic [63:0] wbd);
    id_valid = i.v; id_pc = i.pc; id_rs1_data = i.r1d; id_rs2_data = i.r2d; id_imm = i.imm;
    id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd; id_funct3 = 3'd0; id_funct7 = i.f7;
    id_aluop = i.aluop; id_alusrc = i.alusrc; id_branch = i.br; id_memread = i.mr;
    id_memwrite = 1'b0; id_regwrite = i.rw;
    wb_regwrite = wbw; wb_rd = wbrd; wb_data = wbd;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  localparam int NV = 17;
  vec_t tv[NV];
  inst_t nop;

  initial begin
    nop = '0;
    //               instruction                         wb                 rdy rd rpc     A              B         mv  mres            mrw
    tv[0]  = mkv(alu(1, 2, 3, 5, 7, 0),                  0, 0, 0,           1, 0, 0,     0, 0,         0, 0,    0, 0, 0);
    tv[1]  = mkv(alu(4, 1, 2, 'h99, 5, 'h20),            0, 0, 0,           1, 0, 0,     1, 5,         1, 7,    0, 0, 0);
    tv[2]  = mkv(nop,                                    0, 0, 0,           1, 0, 0,     1, 12,        1, 5,    1, 12, 1);
    tv[3]  = mkv(ld(5, 10, 'h1000),                      0, 0, 0,           1, 0, 0,     0, 0,         0, 0,    1, 7, 1);
    tv[4]  = mkv(alu(6, 5, 0, 'h77, 0, 0),               0, 0, 0,           0, 0, 0,     1, 'h1000,    0, 0,    0, 0, 0);
    tv[5]  = mkv(alu(6, 5, 0, 'h77, 0, 0),               0, 0, 0,           1, 0, 0,     0, 0,         0, 0,    1, 'h1000, 1);
    tv[6]  = mkv(nop,                                    1, 5, 'hDEAD,      1, 0, 0,     1, 'hDEAD,    1, 0,    0, 0, 0);
    tv[7]  = mkv(beq('h100, 3, 3, 8),                    0, 0, 0,           1, 0, 0,     0, 0,         0, 0,    1, 'hDEAD, 1);
    tv[8]  = mkv(alu(9, 2, 3, 5, 7, 0),                  0, 0, 0,           1, 1, 'h110, 1, 3,         1, 3,    0, 0, 0);
    tv[9]  = mkv(nop,                                    0, 0, 0,           1, 0, 0,     0, 0,         0, 0,    1, 0, 0);
    tv[10] = mkv(beq('h200, 1, 2, 4),                    0, 0, 0,           1, 0, 0,     0, 0,         0, 0,    0, 0, 0);
    tv[11] = mkv(alu(0, 2, 3, 5, 7, 0),                  0, 0, 0,           1, 0, 0,     1, 1,         1, 2,    0, 0, 0);
    tv[12] = mkv(alu(12, 0, 0, 0, 0, 0),                 1, 0, 'hBAD,       1, 0, 0,     1, 5,         1, 7,    1, -1, 0);
    tv[13] = mkv(nop,                                    1, 0, 'hBAD,       1, 0, 0,     1, 0,         1, 0,    1, 12, 1);
    tv[14] = mkv(ld(0, 0, 0),                            0, 0, 0,           1, 0, 0,     0, 0,         0, 0,    1, 0, 1);
    tv[15] = mkv(alu(13, 0, 0, 0, 0, 0),                 0, 0, 0,           1, 0, 0,     0, 0,         0, 0,    0, 0, 0);
    tv[16] = mkv(nop,                                    0, 0, 0,           1, 0, 0,     0, 0,         0, 0,    1, 0, 1);

    // reset state
    reset = 1'b1;
    drive(nop, 1'b0, 5'd0, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("rst_id_ready", 64'(id_ready), 64'd1);
    chk("rst_redirect", 64'(redirect), 64'd0);
    chk("rst_redirect_pc", redirect_pc, 64'd0);
    chk("rst_exm_valid", 64'(exm_valid), 64'd0);
    chk("rst_exm_memwrite", 64'(exm_memwrite), 64'd0);
    chk("rst_ex_ctrl", {52'd0, ex_funct3, ex_funct7, ex_aluop, ex_alusrc}, 64'd0);

    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge clk);
      drive(tv[i].ins, tv[i].wbw, tv[i].wbrd, tv[i].wbd);
      #2;
      chk($sformatf("v%0d_id_ready", i), 64'(id_ready), 64'(tv[i].rdy));
      chk($sformatf("v%0d_redirect", i), 64'(redirect), 64'(tv[i].redir));
      chk($sformatf("v%0d_redirect_pc", i), redirect_pc, tv[i].rpc);
      if (tv[i].ca) chk($sformatf("v%0d_ex_A", i), ex_A, tv[i].a);
      if (tv[i].cb) chk($sformatf("v%0d_ex_B", i), ex_B, tv[i].b);
      chk($sformatf("v%0d_exm_valid", i), 64'(exm_valid), 64'(tv[i].mv));
      if (tv[i].mv) begin
        chk($sformatf("v%0d_exm_result", i), exm_result, tv[i].mres);
        chk($sformatf("v%0d_exm_regwrite", i), 64'(exm_regwrite), 64'(tv[i].mrw));
      end
      if (i == 3) chk("v3_exm_store_data", exm_store_data, 64'd5);
      if (i == 5) begin
        chk("v5_exm_memread", 64'(exm_memread), 64'd1);
        chk("v5_exm_rd", 64'(exm_rd), 64'd5);
      end
      if (i == 9) chk("v9_bubble_ctrl", {52'd0, ex_funct3, ex_funct7, ex_aluop, ex_alusrc}, 64'd0);
    end

    // reset with a taken branch in ID/EX and an add in EX/MEM, ID still offering work
    @(negedge clk);
    drive(alu(1, 2, 3, 5, 7, 0), 1'b0, 5'd0, 64'd0);
    @(negedge clk);
    drive(beq('h300, 4, 4, 2), 1'b0, 5'd0, 64'd0);
    @(negedge clk);
    drive(alu(9, 2, 3, 5, 7, 0), 1'b0, 5'd0, 64'd0);
    #2;
    chk("pre_rst_redirect", 64'(redirect), 64'd1);
    chk("pre_rst_redirect_pc", redirect_pc, 64'h304);
    chk("pre_rst_exm_valid", 64'(exm_valid), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    #2;
    chk("mid_rst_redirect", 64'(redirect), 64'd0);
    chk("mid_rst_id_ready", 64'(id_ready), 64'd1);
    chk("mid_rst_exm_valid", 64'(exm_valid), 64'd0);
    chk("mid_rst_ex_ctrl", {52'd0, ex_funct3, ex_funct7, ex_aluop, ex_alusrc}, 64'd0);
    reset = 1'b0;
    drive(nop, 1'b0, 5'd0, 64'd0);
    @(negedge clk);
    #2;
    chk("post_rst_exm_valid", 64'(exm_valid), 64'd0);
    chk("post_rst_redirect", 64'(redirect), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_stage_ctrl.md
EX_STAGE_CTRL -- requirements
Module: ex_stage_ctrl

Interface
REQ-001 Parameter: XLEN, 64, datapath width; every data and PC port below is XLEN bits.
REQ-002 Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- id_valid / id_ready  in / out  1 / 1  decode-to-execute handshake.
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  64 each  decoded operands.
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_funct3 / id_funct7 / id_aluop  in  3 / 7 / 2  ALU control fields.
- id_alusrc, id_branch, id_memread, id_memwrite, id_regwrite  in  1 each  control bits.
- ex_A, ex_B, ex_C, ex_pc  out  64 each  operands to the execute datapath; ex_C is the immediate.
- ex_funct3 / ex_funct7 / ex_aluop / ex_alusrc  out  3 / 7 / 2 / 1  control to the execute datapath.
- ex_zero / ex_result / ex_target  in  1 / 64 / 64  execute datapath outputs.
- wb_regwrite / wb_rd / wb_data  in  1 / 5 / 64  writeback forwarding source.
- exm_valid, exm_rd, exm_regwrite, exm_memread, exm_memwrite, exm_result, exm_store_data  out  EX/MEM register.
- redirect / redirect_pc  out  1 / 64  taken-branch fetch redirect.

Function
REQ-003 The block SHALL hold one ID/EX register with a valid bit ex_v; an instruction SHALL be captured when id_valid && id_ready at a clock edge.
REQ-004 If no instruction is captured at an edge, ex_v SHALL be cleared to 0 at that edge (bubble).
REQ-005 Latency: an instruction accepted at edge N SHALL drive ex_* during cycle N+1 and SHALL appear on exm_* after edge N+1.
REQ-006 Load-use stall = ex_v && ex_memread && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2) && id_valid; id_ready SHALL equal !stall.
REQ-007 During a stall, the ID/EX register SHALL load a bubble, and the upstream instruction SHALL be held and accepted the next cycle.
REQ-008 Forward A: if exm_valid && exm_regwrite && !exm_memread && exm_rd!=0 && exm_rd==ex_rs1, ex_A = exm_result.
- Else if wb_regwrite && wb_rd!=0 && wb_rd==ex_rs1, ex_A = wb_data.
- Else ex_A = latched rs1_data.
REQ-009 ex_B SHALL use the REQ-008 priority on ex_rs2 and SHALL carry the forwarded rs2 value regardless of ex_alusrc; operand selection stays in the datapath.
REQ-010 Register x0 SHALL never be a forwarding or stall match.
REQ-011 redirect SHALL be combinational: ex_v && ex_branch && ex_zero; while redirect=1, redirect_pc SHALL equal ex_target, otherwise redirect_pc SHALL be 0.
REQ-012 While redirect=1, id_ready SHALL be 1, any captured instruction SHALL be discarded, and ex_v SHALL become 0 at the next edge (flush).
REQ-013 Stall and redirect cannot coincide, since the EX instruction cannot be both a load and a branch; if both control bits are set, redirect SHALL take priority.
REQ-014 At each edge, exm_valid SHALL take ex_v.
- exm_result SHALL take ex_result.
- exm_store_data SHALL take forwarded B.
- rd and control SHALL be copied.
- exm_regwrite SHALL be forced to 0 for branches.
REQ-015 The downstream stage SHALL always accept exm_*; there is no backpressure into the block.
REQ-016 Bubbles SHALL drive all ex_* control outputs to 0 (ALUOp 00, alusrc 0).

Reset
REQ-017 While reset=1 at an edge, ex_v, exm_valid and all ID/EX and EX/MEM fields SHALL be cleared to 0.
REQ-018 While ex_v=0 (including during and after reset), redirect SHALL be 0 and id_ready SHALL be 1.
REQ-019 Reset asserted mid-operation SHALL drop all in-flight instructions without a redirect; reset SHALL take priority over the handshake.

Verification
REQ-020 Back-to-back: add x1,x2,x3 (x2=5, x3=7) then sub x4,x1,x2 -> second op sees ex_A=12 via EX/MEM forward; exm_result=7.
REQ-021 Load-use: ld x5 then add x6,x5,x0 -> id_ready=0 for exactly 1 cycle, one bubble (exm_valid=0), add then gets ex_A=wb_data.
REQ-022 Taken beq at pc=0x100, imm=8, operands equal -> redirect=1, redirect_pc=0x110 for one cycle; next instruction flushed, exm_valid=0 one cycle later.
REQ-023 Not-taken beq (ex_zero=0) -> redirect=0, no flush, exm_regwrite=0 for the branch.
REQ-024 Write to x0 followed by a read of x0 -> no forwarding, ex_A=rs1_data=0, no stall.
REQ-025 Reset asserted with valid instructions in ID/EX and EX/MEM -> the edge after reset clears ex_v=0, exm_valid=0, redirect=0, id_ready=1.
